neopixel_frame_scheduler: RTL and testbench

- Sequences the 8-pixel Neopixel controller on behalf of game logic.
- Holds a shadow framebuffer of NUM_PIXELS×24-bit colours, written at any time by the game FSM.
- On commit, or on an optional periodic refresh, it snapshots the buffer and streams it into the controller with load/pixel strobes. It then issues go, tracks the controller's ready handshake, and reports frame completion.
- Sits between the game datapath and NeopixelController; it is the only driver of the controller's load/go/pixel/colour inputs.

---
 rtl/neopixel_frame_scheduler.sv | 140 ++++++++++++++
 tb/tb_neopixel_frame_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_frame_scheduler.sv
// rtl/neopixel_frame_scheduler.sv - shadow framebuffer and frame sequencer for a Neopixel controller
// Snapshots the shadow buffer on commit or refresh and streams it out with load/go strobes.
module neopixel_frame_scheduler #(
  parameter int NUM_PIXELS     = 8,
  parameter int PIX_W          = $clog2(NUM_PIXELS),
  parameter int COLOR_W        = 8,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [PIX_W-1:0]   wr_pixel,
  input  logic [COLOR_W-1:0] wr_red,
  input  logic [COLOR_W-1:0] wr_green,
  input  logic [COLOR_W-1:0] wr_blue,
  input  logic               commit,
  output logic               busy,
  output logic               frame_done,
  input  logic               npc_ready,
  output logic               npc_load,
  output logic [PIX_W-1:0]   npc_pixel,
  output logic [COLOR_W-1:0] npc_red,
  output logic [COLOR_W-1:0] npc_green,
  output logic [COLOR_W-1:0] npc_blue,
  output logic               npc_go
);
  localparam int RGB_W = 3 * COLOR_W;
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam bit REFRESH_EN = (REFRESH_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [PIX_W-1:0] IDX_LAST = PIX_W'(NUM_PIXELS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RDY  = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_GO        = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  logic [RGB_W-1:0] buf_q  [NUM_PIXELS];
  logic [RGB_W-1:0] snap_q [NUM_PIXELS];
  logic [2:0]       state_q, state_d;
  logic [PIX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             resume_q, resume_d;
  logic             done_q, done_d;
  logic             snap_take;
  logic             refresh_fire;
  logic             wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_pixel} < (PIX_W + 1)'(NUM_PIXELS));
  assign refresh_fire = REFRESH_EN && (state_q == S_IDLE) && !pending_q && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    resume_d  = resume_q;
    done_d    = 1'b0;
    snap_take = 1'b0;
    case (state_q)
      S_IDLE: if (pending_q) state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (npc_ready) begin
          // A frame interrupted by ready dropping resumes from its existing snapshot.
          snap_take = !resume_q;
          resume_d  = 1'b0;
          idx_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!npc_ready) begin
          resume_d = 1'b1;
          idx_d    = '0;
          state_d  = S_WAIT_RDY;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_GO;
        end else begin
          idx_d = idx_q + PIX_W'(1);
        end
      end
      S_GO: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!npc_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (npc_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A commit in the snapshot cycle wins, so it queues the following frame.
  always_comb begin
    pending_d = pending_q;
    if (snap_take) pending_d = 1'b0;
    if (commit || refresh_fire) pending_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != S_IDLE) || pending_q || commit || refresh_fire) cnt_d = '0;
    else if (REFRESH_EN) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      resume_q  <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        buf_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      resume_q  <= resume_d;
      done_q    <= done_d;
      if (snap_take) begin
        for (int i = 0; i < NUM_PIXELS; i++) snap_q[i] <= buf_q[i];
      end
      if (wr_ok) buf_q[wr_pixel] <= {wr_red, wr_green, wr_blue};
    end
  end

  assign npc_load   = (state_q == S_LOAD);
  assign npc_go     = (state_q == S_GO);
  assign npc_pixel  = npc_load ? idx_q : '0;
  assign {npc_red, npc_green, npc_blue} = npc_load ? snap_q[idx_q] : '0;
  assign frame_done = done_q;
  assign busy       = pending_q || (state_q != S_IDLE);
endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// tb/tb_neopixel_frame_scheduler.sv - randomized self-checking bench for neopixel_frame_scheduler
// Instance 0 is commit-driven, instance 1 runs with a 100-cycle auto-refresh.
module tb_neopixel_frame_scheduler;
  localparam int NP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] wr_en, commit, busy, frame_done, npc_load, npc_go, npc_ready;
  logic [1:0] ready_model = 2'b11;
  logic [1:0] force_low   = 2'b00;
  logic [2:0] wr_pixel [2];
  logic [2:0] npc_pixel [2];
  logic [7:0] wr_r [2], wr_g [2], wr_b [2];
  logic [7:0] npc_r [2], npc_g [2], npc_b [2];

  assign npc_ready = ready_model & ~force_low;

  neopixel_frame_scheduler #(.REFRESH_CYCLES(0)) u_dut_a (
    .CLOCK_50(clk), .reset(rst_n), .wr_en(wr_en[0]), .wr_pixel(wr_pixel[0]),
    .wr_red(wr_r[0]), .wr_green(wr_g[0]), .wr_blue(wr_b[0]), .commit(commit[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .npc_ready(npc_ready[0]),
    .npc_load(npc_load[0]), .npc_pixel(npc_pixel[0]), .npc_red(npc_r[0]),
    .npc_green(npc_g[0]), .npc_blue(npc_b[0]), .npc_go(npc_go[0])
  );

  neopixel_frame_scheduler #(.REFRESH_CYCLES(100)) u_dut_b (
    .CLOCK_50(clk), .reset(rst_n), .wr_en(wr_en[1]), .wr_pixel(wr_pixel[1]),
    .wr_red(wr_r[1]), .wr_green(wr_g[1]), .wr_blue(wr_b[1]), .commit(commit[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .npc_ready(npc_ready[1]),
    .npc_load(npc_load[1]), .npc_pixel(npc_pixel[1]), .npc_red(npc_r[1]),
    .npc_green(npc_g[1]), .npc_blue(npc_b[1]), .npc_go(npc_go[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: shadow buffers, expected frame, and what each controller saw.
  logic [23:0] exp_buf [2][NP];
  logic [23:0] ref_arr [NP];
  logic [2:0]  ld_pix [2][$];
  logic [23:0] ld_col [2][$];
  int          ld_cyc [2][$];
  int          dn_cyc [2][$];
  int          go_cnt [2], go_cyc [2], ld_low [2], go_low [2], go_ld [2];
  int          ctrl_n [2], cnt_m [2];
  bit          go_seen [2];

  // Controller model: ready drops the cycle after go and returns ctrl_n cycles later.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        ready_model[u] = 1'b1;
        cnt_m[u]       = 0;
        go_seen[u]     = 1'b0;
      end else begin
        if (npc_load[u]) begin
          ld_pix[u].push_back(npc_pixel[u]);
          ld_col[u].push_back({npc_r[u], npc_g[u], npc_b[u]});
          ld_cyc[u].push_back(cyc);
          if (!npc_ready[u]) ld_low[u]++;
        end
        if (npc_go[u]) begin
          go_cnt[u]++;
          go_cyc[u] = cyc;
          if (!npc_ready[u]) go_low[u]++;
          if (npc_load[u]) go_ld[u]++;
        end
        if (frame_done[u]) dn_cyc[u].push_back(cyc);
        if (go_seen[u]) begin
          ready_model[u] = 1'b0;
          cnt_m[u]       = ctrl_n[u];
          go_seen[u]     = 1'b0;
        end else if (cnt_m[u] > 0) begin
          cnt_m[u]--;
          if (cnt_m[u] == 0) ready_model[u] = 1'b1;
        end
        if (npc_go[u]) go_seen[u] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(int u);
    ld_pix[u].delete();
    ld_col[u].delete();
    ld_cyc[u].delete();
    dn_cyc[u].delete();
    go_cnt[u] = 0;
  endtask

  task automatic do_write(int u, int pix, logic [23:0] col);
    logic [2:0] p;
    p = pix[2:0];
    wr_en[u] = 1'b1;
    wr_pixel[u] = p;
    {wr_r[u], wr_g[u], wr_b[u]} = col;
    tick();
    wr_en[u] = 1'b0;
    exp_buf[u][pix] = col;
  endtask

  task automatic pulse_commit(int u);
    commit[u] = 1'b1;
    tick();
    commit[u] = 1'b0;
  endtask

  task automatic wait_done(int u, int n, int budget);
    for (int i = 0; i < budget && dn_cyc[u].size() < n; i++) tick();
  endtask

  task automatic wait_load_pix(int u, int pix, int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ld_pix[u].size() > 0 && ld_pix[u][$] == 3'(pix)) break;
    end
  endtask

  task automatic load_ref(int u);
    for (int i = 0; i < NP; i++) ref_arr[i] = exp_buf[u][i];
  endtask

  function automatic int frame_errs(int u, int base);
    int n = 0;
    for (int i = 0; i < NP; i++) begin
      if (base < 0 || base + i >= ld_pix[u].size()) n++;
      else if (ld_pix[u][base + i] !== 3'(i) || ld_col[u][base + i] !== ref_arr[i]) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy[0], frame_done[0], npc_load[0], npc_go[0], npc_pixel[0], npc_r[0], npc_g[0], npc_b[0]} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %0h, expected 0", {busy[0], npc_load[0], npc_go[0], npc_pixel[0]});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy[0], frame_done[0], npc_load[0], npc_go[0]} !== 4'd0) begin
      errors++; $display("FAIL idle_after_reset_a: got %0h, expected 0", {busy[0], frame_done[0], npc_load[0], npc_go[0]});
    end
    checks++;
    if ({busy[1], npc_load[1], npc_go[1]} !== 3'd0) begin
      errors++; $display("FAIL idle_after_reset_b: got %0h, expected 0", {busy[1], npc_load[1], npc_go[1]});
    end
  endtask

  task automatic test_single_frame();
    int k, busy_low;
    ctrl_n[0] = 1200;
    do_write(0, 3, 24'h123456);
    clear_mon(0);
    busy_low = 0;
    k = cyc;
    pulse_commit(0);
    for (int i = 0; i < 2000; i++) begin
      if (dn_cyc[0].size() > 0) break;
      if (!busy[0]) busy_low++;
      tick();
    end
    load_ref(0);
    checks++;
    if (dn_cyc[0].size() !== 1) begin errors++; $display("FAIL single_done_count: got %0d, expected 1", dn_cyc[0].size()); end
    checks++;
    if (ld_pix[0].size() !== NP) begin errors++; $display("FAIL single_load_count: got %0d, expected %0d", ld_pix[0].size(), NP); end
    checks++;
    if (frame_errs(0, 0) !== 0) begin errors++; $display("FAIL single_frame_data: got %0d bad pixels, expected 0", frame_errs(0, 0)); end
    checks++;
    if ((ld_cyc[0].size() > 0 ? ld_cyc[0][0] : -1) !== k + 3) begin
      errors++; $display("FAIL commit_latency: got cycle %0d, expected %0d", ld_cyc[0].size() > 0 ? ld_cyc[0][0] : -1, k + 3);
    end
    checks++;
    if ((ld_cyc[0].size() == NP ? ld_cyc[0][NP-1] - ld_cyc[0][0] : -1) !== NP - 1) begin
      errors++; $display("FAIL load_consecutive: got span %0d, expected %0d", ld_cyc[0].size() == NP ? ld_cyc[0][NP-1] - ld_cyc[0][0] : -1, NP - 1);
    end
    checks++;
    if (go_cnt[0] !== 1 || go_cyc[0] !== (ld_cyc[0].size() == NP ? ld_cyc[0][NP-1] + 1 : -1)) begin
      errors++; $display("FAIL go_after_last_load: got count %0d at cycle %0d, expected 1 right after last load", go_cnt[0], go_cyc[0]);
    end
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL busy_during_frame: got %0d idle cycles, expected 0", busy_low); end
    checks++;
    if ((dn_cyc[0].size() > 0 ? dn_cyc[0][0] : 0) <= go_cyc[0] + 1200) begin
      errors++; $display("FAIL done_before_ready: got cycle %0d, expected after %0d", dn_cyc[0].size() > 0 ? dn_cyc[0][0] : 0, go_cyc[0] + 1200);
    end
    repeat (20) tick();
    checks++;
    if (busy[0] !== 1'b0 || dn_cyc[0].size() !== 1 || ld_pix[0].size() !== NP) begin
      errors++; $display("FAIL idle_after_frame: got busy=%0b dones=%0d loads=%0d, expected 0/1/%0d", busy[0], dn_cyc[0].size(), ld_pix[0].size(), NP);
    end
  endtask

  task automatic test_coalesce();
    logic [23:0] c7;
    ctrl_n[0] = 60;
    clear_mon(0);
    pulse_commit(0);
    for (int i = 0; i < 50 && go_cnt[0] == 0; i++) tick();
    repeat (5) tick();
    repeat (3) begin
      pulse_commit(0);
      tick();
    end
    do_write(0, 7, 24'hFF0000);
    wait_done(0, 2, 400);
    repeat (150) tick();
    load_ref(0);
    checks++;
    if (dn_cyc[0].size() !== 2) begin errors++; $display("FAIL coalesce_done_count: got %0d, expected 2", dn_cyc[0].size()); end
    checks++;
    if (go_cnt[0] !== 2 || ld_pix[0].size() !== 2 * NP) begin
      errors++; $display("FAIL coalesce_frames: got go=%0d loads=%0d, expected 2/%0d", go_cnt[0], ld_pix[0].size(), 2 * NP);
    end
    checks++;
    if (frame_errs(0, NP) !== 0) begin errors++; $display("FAIL coalesce_frame_data: got %0d bad pixels, expected 0", frame_errs(0, NP)); end
    c7 = (ld_col[0].size() >= 2 * NP) ? ld_col[0][2*NP-1] : 24'h0;
    checks++;
    if (c7[23:16] !== 8'hFF) begin errors++; $display("FAIL coalesce_pixel7_red: got %0h, expected ff", c7[23:16]); end
    checks++;
    if ((ld_cyc[0].size() > NP && dn_cyc[0].size() > 0) ? (ld_cyc[0][NP] - dn_cyc[0][0]) !== 2 : 1'b1) begin
      errors++; $display("FAIL back_to_back_start: got gap %0d, expected 2", (ld_cyc[0].size() > NP && dn_cyc[0].size() > 0) ? ld_cyc[0][NP] - dn_cyc[0][0] : -1);
    end
  endtask

  task automatic test_ready_drop();
    int n, gap;
    ctrl_n[0] = 20;
    for (int i = 0; i < NP; i++) do_write(0, i, 24'($urandom));
    load_ref(0);
    clear_mon(0);
    pulse_commit(0);
    wait_load_pix(0, 4, 30);
    force_low[0] = 1'b1;
    do_write(0, 0, ref_arr[0] ^ 24'h800001);
    repeat (4) tick();
    force_low[0] = 1'b0;
    wait_done(0, 1, 200);
    n = ld_pix[0].size();
    checks++;
    if (dn_cyc[0].size() !== 1 || go_cnt[0] !== 1) begin
      errors++; $display("FAIL drop_single_go: got go=%0d dones=%0d, expected 1/1", go_cnt[0], dn_cyc[0].size());
    end
    checks++;
    if (ld_low[0] !== 0) begin errors++; $display("FAIL drop_load_while_low: got %0d, expected 0", ld_low[0]); end
    checks++;
    if (frame_errs(0, n - NP) !== 0) begin errors++; $display("FAIL drop_resume_data: got %0d bad pixels, expected 0", frame_errs(0, n - NP)); end
    checks++;
    if ((n > NP ? ld_pix[0][n-NP-1] : 3'd0) !== 3'd4) begin
      errors++; $display("FAIL drop_last_before_pause: got %0d, expected 4", n > NP ? ld_pix[0][n-NP-1] : 3'd0);
    end
    gap = (n > NP) ? ld_cyc[0][n-NP] - ld_cyc[0][n-NP-1] : 0;
    checks++;
    if (gap < 6) begin errors++; $display("FAIL drop_pause_length: got %0d, expected at least 6", gap); end
  endtask

  task automatic test_random_frames();
    repeat (3) begin
      ctrl_n[0] = 5 + int'($urandom_range(0, 20));
      for (int i = 0; i < NP; i++) do_write(0, i, 24'($urandom));
      load_ref(0);
      clear_mon(0);
      pulse_commit(0);
      wait_done(0, 1, 200);
      checks++;
      if (dn_cyc[0].size() !== 1) begin errors++; $display("FAIL random_done: got %0d, expected 1", dn_cyc[0].size()); end
      checks++;
      if (frame_errs(0, 0) !== 0) begin errors++; $display("FAIL random_frame_data: got %0d bad pixels, expected 0", frame_errs(0, 0)); end
    end
  endtask

  task automatic test_refresh();
    int fd;
    clear_mon(1);
    wait_done(1, 1, 400);
    fd = (dn_cyc[1].size() > 0) ? dn_cyc[1][0] : -1000;
    ld_pix[1].delete();
    ld_col[1].delete();
    ld_cyc[1].delete();
    do_write(1, 2, 24'($urandom) | 24'h000100);
    for (int i = 0; i < 300 && ld_pix[1].size() < NP; i++) tick();
    load_ref(1);
    checks++;
    if ((ld_cyc[1].size() > 0 ? ld_cyc[1][0] - fd : -1) !== 102) begin
      errors++; $display("FAIL refresh_interval_1: got %0d, expected 102", ld_cyc[1].size() > 0 ? ld_cyc[1][0] - fd : -1);
    end
    checks++;
    if (frame_errs(1, 0) !== 0) begin errors++; $display("FAIL refresh_frame_data: got %0d bad pixels, expected 0", frame_errs(1, 0)); end
    wait_done(1, 2, 600);
    for (int i = 0; i < 300 && ld_pix[1].size() < 2 * NP; i++) tick();
    checks++;
    if ((ld_cyc[1].size() > NP && dn_cyc[1].size() > 1) ? (ld_cyc[1][NP] - dn_cyc[1][1]) !== 102 : 1'b1) begin
      errors++; $display("FAIL refresh_interval_2: got %0d, expected 102", (ld_cyc[1].size() > NP && dn_cyc[1].size() > 1) ? ld_cyc[1][NP] - dn_cyc[1][1] : -1);
    end
    checks++;
    if (frame_errs(1, NP) !== 0) begin errors++; $display("FAIL refresh_repeat_data: got %0d bad pixels, expected 0", frame_errs(1, NP)); end
  endtask

  task automatic test_reset_mid_frame();
    ctrl_n[0] = 10;
    for (int i = 0; i < NP; i++) do_write(0, i, 24'($urandom) | 24'h010101);
    clear_mon(0);
    pulse_commit(0);
    wait_load_pix(0, 5, 30);
    checks++;
    if (npc_load[0] !== 1'b1 || npc_pixel[0] !== 3'd5) begin
      errors++; $display("FAIL midreset_reached_idx5: got load=%0b pixel=%0d, expected 1/5", npc_load[0], npc_pixel[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[0], frame_done[0], npc_load[0], npc_go[0], npc_pixel[0], npc_r[0], npc_g[0], npc_b[0]} !== 30'd0) begin
      errors++; $display("FAIL midreset_async_outputs: got load=%0b pixel=%0d rgb=%0h, expected 0", npc_load[0], npc_pixel[0], {npc_r[0], npc_g[0], npc_b[0]});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) for (int i = 0; i < NP; i++) exp_buf[u][i] = 24'h0;
    clear_mon(0);
    repeat (50) tick();
    checks++;
    if (ld_pix[0].size() !== 0 || go_cnt[0] !== 0) begin
      errors++; $display("FAIL midreset_no_strobes: got loads=%0d go=%0d, expected 0/0", ld_pix[0].size(), go_cnt[0]);
    end
    pulse_commit(0);
    wait_done(0, 1, 200);
    load_ref(0);
    checks++;
    if (frame_errs(0, 0) !== 0) begin errors++; $display("FAIL midreset_buffer_cleared: got %0d bad pixels, expected 0", frame_errs(0, 0)); end
  endtask

  task automatic test_invariants();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (go_ld[u] !== 0) begin errors++; $display("FAIL go_with_load_%0d: got %0d, expected 0", u, go_ld[u]); end
      checks++;
      if (go_low[u] !== 0) begin errors++; $display("FAIL go_while_not_ready_%0d: got %0d, expected 0", u, go_low[u]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = '0;
    commit = '0;
    for (int u = 0; u < 2; u++) begin
      wr_pixel[u] = '0; wr_r[u] = '0; wr_g[u] = '0; wr_b[u] = '0;
      ctrl_n[u] = 20; go_cnt[u] = 0; go_cyc[u] = 0; ld_low[u] = 0; go_low[u] = 0; go_ld[u] = 0;
      for (int i = 0; i < NP; i++) exp_buf[u][i] = 24'h0;
    end
    test_reset();
    test_single_frame();
    test_coalesce();
    test_ready_drop();
    test_random_frames();
    test_refresh();
    test_reset_mid_frame();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
